// File: rtl/cordic_pkg.sv
// Shared CORDIC constants and helpers for the vectoring estimator and the rotation-mode corrector.
// Phase is signed Q3.28 throughout, with PI = 843314856.
package cordic_pkg;

    localparam int PHASE_W    = 32;
    localparam int PHASE_FRAC = 28;
    localparam int ATAN_DEPTH = 29;

    localparam logic signed [PHASE_W-1:0] PI      = 32'sd843314856;
    localparam logic signed [PHASE_W-1:0] HALF_PI = 32'sd421657428;

    // 1.64676 in Q2.14
    localparam logic [15:0] CORDIC_GAIN_Q = 16'd26980;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // atan(2^-k) in Q3.28, k = 0..28
    localparam logic [PHASE_W-1:0] ATAN_TABLE [0:ATAN_DEPTH-1] = '{
        32'd210828714, 32'd124459457, 32'd65760959, 32'd33381290,
        32'd16755422,  32'd8385879,   32'd4193963,  32'd2097109,
        32'd1048571,   32'd524287,    32'd262144,   32'd131072,
        32'd65536,     32'd32768,     32'd16384,    32'd8192,
        32'd4096,      32'd2048,      32'd1024,     32'd512,
        32'd256,       32'd128,       32'd64,       32'd32,
        32'd16,        32'd8,         32'd4,        32'd2,
        32'd1
    };

    // Clamp a widened phase accumulator to [-PI, +PI] so overshoot never wraps.
    function automatic logic signed [PHASE_W-1:0] phase_sat(input logic signed [PHASE_W+1:0] z);
        logic signed [PHASE_W+1:0] pi_w;
        pi_w = (PHASE_W+2)'(PI);
        if (z > pi_w)
            return PI;
        else if (z < -pi_w)
            return -PI;
        else
            return z[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/cordic_atan_lut.sv
// Combinational arctangent ROM indexed by the CORDIC iteration counter.
// Indices past the table end read as zero.
module cordic_atan_lut
    import cordic_pkg::*;
(
    input  logic [4:0]         idx,
    output logic [PHASE_W-1:0] atan_val
);

    always_comb begin
        atan_val = '0;
        if (idx < 5'(ATAN_DEPTH))
            atan_val = ATAN_TABLE[idx];
    end

endmodule

// File: rtl/cordic_vectoring_atan.sv
// Iterative vectoring-mode CORDIC: one (I,Q) sample in, atan2(Q,I) and gain-scaled magnitude out.
// state | meaning
// IDLE  | waiting for Input_strobe
// CALC  | one micro-rotation per clock, Busy high
// DONE  | outputs registered, Out_VALID pulsed; may accept the next sample
module cordic_vectoring_atan
    import cordic_pkg::*;
#(
    parameter int N_ITER = 20,
    parameter int IW     = 16,
    parameter int GW     = 2
) (
    input  logic                       CLK,
    input  logic                       s_RST,
    input  logic                       Input_strobe,
    input  logic signed [IW-1:0]       I_in,
    input  logic signed [IW-1:0]       Q_in,
    output logic                       Busy,
    output logic                       Out_VALID,
    output logic signed [PHASE_W-1:0]  Phase_out,
    output logic [IW+1:0]              Mag_out
);

    // Fraction bits below the integer datapath keep the floor bias of >>> on
    // negative y (stuck at -1) from creeping into the magnitude.
    localparam int FRAC_W = 8;
    localparam int XW     = IW + GW + FRAC_W;
    localparam int ZW     = PHASE_W + 2;

    localparam logic signed [ZW-1:0] PI_Z = ZW'(PI);

    logic [1:0]             state;
    logic [4:0]             cnt;
    logic signed [XW-1:0]   x_q, y_q;
    logic signed [ZW-1:0]   z_q;
    logic                   zero_q;
    logic                   axis_q;

    logic signed [XW-1:0]   i_ext, q_ext;
    logic signed [XW-1:0]   cap_x, cap_y;
    logic signed [ZW-1:0]   cap_z;
    logic                   cap_zero, cap_axis;

    logic [PHASE_W-1:0]     atan_val;
    logic signed [ZW-1:0]   atan_ext;
    logic signed [XW-1:0]   x_sh, y_sh;
    logic signed [XW-1:0]   x_nxt, y_nxt;
    logic signed [ZW-1:0]   z_nxt;

    cordic_atan_lut u_atan_lut (
        .idx      (cnt),
        .atan_val (atan_val)
    );

    assign i_ext = {{GW{I_in[IW-1]}}, I_in, {FRAC_W{1'b0}}};
    assign q_ext = {{GW{Q_in[IW-1]}}, Q_in, {FRAC_W{1'b0}}};

    always_comb begin
        cap_x    = i_ext;
        cap_y    = q_ext;
        cap_z    = '0;
        cap_zero = (I_in == '0) && (Q_in == '0);
        // Negative real axis is pinned to +PI rather than trusting the residual sign.
        cap_axis = I_in[IW-1] && (Q_in == '0);
        if (I_in[IW-1]) begin
            cap_x = -i_ext;
            cap_y = -q_ext;
            cap_z = Q_in[IW-1] ? -PI_Z : PI_Z;
        end
    end

    assign atan_ext = {2'b00, atan_val};
    assign x_sh     = x_q >>> cnt;
    assign y_sh     = y_q >>> cnt;

    always_comb begin
        x_nxt = x_q + y_sh;
        y_nxt = y_q - x_sh;
        z_nxt = z_q + atan_ext;
        if (y_q[XW-1]) begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_ext;
        end
    end

    assign Busy = (state == ST_CALC);

    always_ff @(posedge CLK) begin
        if (s_RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            zero_q    <= 1'b0;
            axis_q    <= 1'b0;
            Out_VALID <= 1'b0;
            Phase_out <= '0;
            Mag_out   <= '0;
        end else begin
            Out_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Input_strobe) begin
                        x_q    <= cap_x;
                        y_q    <= cap_y;
                        z_q    <= cap_z;
                        zero_q <= cap_zero;
                        axis_q <= cap_axis;
                        cnt    <= '0;
                        state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    x_q <= x_nxt;
                    y_q <= y_nxt;
                    z_q <= z_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(N_ITER - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    Out_VALID <= 1'b1;
                    if (zero_q) begin
                        Phase_out <= '0;
                        Mag_out   <= '0;
                    end else begin
                        Phase_out <= axis_q ? PI : phase_sat(z_q);
                        Mag_out   <= x_q[FRAC_W +: IW+2];
                    end
                    if (Input_strobe) begin
                        x_q    <= cap_x;
                        y_q    <= cap_y;
                        z_q    <= cap_z;
                        zero_q <= cap_zero;
                        axis_q <= cap_axis;
                        cnt    <= '0;
                        state  <= ST_CALC;
                    end else begin
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring_atan.sv
// Directed-vector bench for cordic_vectoring_atan with hand-computed phase/magnitude expectations.
module tb_cordic_vectoring_atan;

    localparam int N_ITER = 20;
    localparam int IW     = 16;
    localparam int GW     = 2;
    localparam int BUDGET = 200;

    localparam longint PI_V      = 843314856;
    localparam longint HALF_PI_V = 421657428;

    logic                     CLK;
    logic                     s_RST;
    logic                     Input_strobe;
    logic signed [IW-1:0]     I_in;
    logic signed [IW-1:0]     Q_in;
    logic                     Busy;
    logic                     Out_VALID;
    logic signed [31:0]       Phase_out;
    logic [IW+1:0]            Mag_out;

    int n_checks = 0;
    int n_errors = 0;

    int     lat;
    longint ph;
    longint mg;

    cordic_vectoring_atan #(.N_ITER(N_ITER), .IW(IW), .GW(GW)) dut (
        .CLK          (CLK),
        .s_RST        (s_RST),
        .Input_strobe (Input_strobe),
        .I_in         (I_in),
        .Q_in         (Q_in),
        .Busy         (Busy),
        .Out_VALID    (Out_VALID),
        .Phase_out    (Phase_out),
        .Mag_out      (Mag_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input longint obs, input longint exp, input longint tol);
        longint d;
        n_checks++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Wait for the next Out_VALID; lat counts edges from the call, -1 on timeout.
    task automatic wait_valid();
        lat = -1;
        for (int c = 1; c <= BUDGET; c++) begin
            @(posedge CLK); #1;
            if (Out_VALID) begin
                lat = c;
                ph  = longint'(Phase_out);
                mg  = longint'(Mag_out);
                break;
            end
        end
        if (lat < 0) check_val("valid_timeout", 0, 1, 0);
    endtask

    // Present one sample for a single accepted edge, then collect its result.
    task automatic run_sample(input int i_v, input int q_v);
        I_in = IW'(i_v);
        Q_in = IW'(q_v);
        Input_strobe = 1'b1;
        @(posedge CLK); #1;
        Input_strobe = 1'b0;
        wait_valid();
    endtask

    initial begin
        int n_valid;
        s_RST = 1'b1;
        Input_strobe = 1'b0;
        I_in = '0;
        Q_in = '0;
        repeat (3) @(posedge CLK);
        #1;
        check_val("rst_busy",  longint'(Busy), 0, 0);
        check_val("rst_valid", longint'(Out_VALID), 0, 0);
        check_val("rst_phase", longint'(Phase_out), 0, 0);
        check_val("rst_mag",   longint'(Mag_out), 0, 0);
        s_RST = 1'b0;
        @(posedge CLK); #1;

        run_sample(16384, 0);
        check_val("lat_pos_i",   lat, N_ITER + 1, 0);
        check_val("ph_pos_i",    ph, 0, 2048);
        check_val("mag_pos_i",   mg, 26981, 4);

        run_sample(0, 16384);
        check_val("ph_pos_q",    ph, HALF_PI_V, 2048);
        check_val("mag_pos_q",   mg, 26981, 4);
        run_sample(0, -16384);
        check_val("ph_neg_q",    ph, -HALF_PI_V, 2048);

        run_sample(-16384, 0);
        check_val("ph_neg_axis", ph, PI_V, 0);
        // atan(1/32768) = 8192 LSB above -PI
        run_sample(-32768, -1);
        check_val("ph_min_i",    ph, -PI_V + 8192, 2048);
        check_val("mag_min_i",   mg, 53961, 8);

        run_sample(-10000, -10000);
        check_val("ph_q3",       ph, -632486142, 2048);
        check_val("mag_q3",      mg, 23289, 8);
        run_sample(0, 0);
        check_val("ph_zero",     ph, 0, 0);
        check_val("mag_zero",    mg, 0, 0);
        check_val("lat_zero",    lat, N_ITER + 1, 0);

        // Strobe held high: each result must belong to the sample present at its accept edge.
        I_in = 16'sd16384;
        Q_in = 16'sd0;
        Input_strobe = 1'b1;
        @(posedge CLK); #1;
        I_in = 16'sd0;
        Q_in = 16'sd16384;
        repeat (2) @(posedge CLK);
        #1;
        check_val("busy_ignore", longint'(Busy), 1, 0);
        wait_valid();
        check_val("b2b_lat0",    lat, N_ITER - 1, 0);
        check_val("b2b_ph0",     ph, 0, 2048);
        I_in = -16'sd10000;
        Q_in = -16'sd10000;
        wait_valid();
        check_val("b2b_lat1",    lat, N_ITER + 1, 0);
        check_val("b2b_ph1",     ph, HALF_PI_V, 2048);
        Input_strobe = 1'b0;
        wait_valid();
        check_val("b2b_lat2",    lat, N_ITER + 1, 0);
        check_val("b2b_ph2",     ph, -632486142, 2048);
        check_val("b2b_mag2",    mg, 23289, 8);

        // Reset during iteration 7 discards the in-flight sample.
        I_in = 16'sd16384;
        Q_in = 16'sd16384;
        Input_strobe = 1'b1;
        @(posedge CLK); #1;
        Input_strobe = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        s_RST = 1'b1;
        @(posedge CLK); #1;
        check_val("mid_rst_busy",  longint'(Busy), 0, 0);
        check_val("mid_rst_valid", longint'(Out_VALID), 0, 0);
        check_val("mid_rst_phase", longint'(Phase_out), 0, 0);
        check_val("mid_rst_mag",   longint'(Mag_out), 0, 0);
        @(posedge CLK); #1;
        s_RST = 1'b0;
        n_valid = 0;
        for (int c = 0; c < N_ITER + 5; c++) begin
            @(posedge CLK); #1;
            if (Out_VALID) n_valid++;
        end
        check_val("no_stale_valid", n_valid, 0, 0);
        run_sample(1000, 1000);
        check_val("lat_post_rst", lat, N_ITER + 1, 0);
        check_val("ph_post_rst",  ph, 210828714, 2048);
        check_val("mag_post_rst", mg, 2329, 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cordic_vectoring_atan.md
Name: cordic_vectoring_atan

Overview:
Iterative CORDIC in vectoring mode. Takes one complex sample (I,Q) and returns its phase atan2(Q,I) and its un-normalised magnitude. It is the estimator partner of the rotation-mode phase corrector: it turns the long-preamble autocorrelation into the frequency-offset phase that the corrector consumes. Phase format matches the corrector exactly: signed 32-bit, 28 fractional bits, PI = 843314856.

Parameters:
N_ITER, 20, number of micro-rotations (1 per clock), legal range 8..28
IW, 16, input I/Q width, signed
GW, 2, guard bits added internally for CORDIC gain and negation headroom

Ports:
CLK  in  1  clock
s_RST  in  1  synchronous active-high reset
Input_strobe  in  1  one-cycle request; samples I_in/Q_in when accepted
I_in  in  IW  signed real part
Q_in  in  IW  signed imaginary part
Busy  out  1  high while iterating; strobes are ignored while high
Out_VALID  out  1  one-cycle pulse; Phase_out/Mag_out are valid this cycle
Phase_out  out  32  signed phase, Q3.28, range [-PI, +PI]
Mag_out  out  IW+2  unsigned magnitude × CORDIC gain (≈1.64676), not normalised

Behaviour:
- Reset (s_RST=1 at a CLK edge) forces: state IDLE, Busy=0, Out_VALID=0, Phase_out=0, Mag_out=0, counter=0. Applies mid-calculation; the in-flight sample is discarded and no Out_VALID pulse is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE: if Input_strobe=1, capture the sample and go to CALC; otherwise stay in IDLE.
- CALC: run iteration k = counter, then increment counter. After iteration N_ITER-1, go to DONE.
- DONE: register the outputs and pulse Out_VALID.
  - If Input_strobe=1 in DONE, capture the new sample and go to CALC (back-to-back operation, no idle gap).
  - Otherwise go to IDLE.
- Latency: strobe accepted at edge 0 → Out_VALID high in the cycle after edge N_ITER+1. Throughput is 1 sample per N_ITER+1 cycles.
- Busy=1 in CALC. Busy=0 in IDLE and DONE. Input_strobe while Busy=1 is ignored: no queuing, no error flag.
- Capture and quadrant pre-rotation (x, y are IW+GW bits, sign-extended):
  - I_in ≥ 0: x=I, y=Q, z=0.
  - I_in < 0: x=-I, y=-Q; z=+PI if Q_in ≥ 0, else -PI.
  - Negating -2^(IW-1) is exact thanks to the guard bits.
- Iteration k:
  - If y ≥ 0: x += y>>>k; y -= x>>>k; z += ATAN[k].
  - Else: x -= y>>>k; y += x>>>k; z -= ATAN[k].
  - Shifts are arithmetic, using the pre-update x and y.
- Outputs:
  - Phase_out = z, saturated to [-PI, +PI] so that residual overshoot never wraps.
  - Mag_out = x. x is always ≥ 0 after pre-rotation.
- Zero input: I_in=0 and Q_in=0 latches a zero flag. The result is then Phase_out=0, Mag_out=0, with the same latency.
- I_in < 0, Q_in = 0 gives +PI (never -PI).
- Phase_out and Mag_out hold their value between Out_VALID pulses.

Decomposition:
- Shared package cordic_pkg:
  - PI = 843314856, HALF_PI = 421657428, PHASE_W = 32, PHASE_FRAC = 28
  - ATAN LUT constants [0..28] (210828714, 124459457, ... , 1)
  - CORDIC_GAIN_Q = 1.64676 in Q2.14
  - The phase corrector moves to this package too.
- One sub-module, cordic_atan_lut: a combinational ROM indexed by the iteration counter, shared with the rotation-mode corrector.

Test Plan:
1. I=16384, Q=0 → Phase_out = 0 ±2048 LSB, Mag_out = 26981 ±4, Out_VALID exactly N_ITER+1 cycles after the strobe.
2. I=0, Q=16384 → Phase_out = 421657428 ±2048; I=0, Q=-16384 → -421657428 ±2048.
3. I=-16384, Q=0 → Phase_out = 843314856 exactly (saturated +PI); I=-32768, Q=-1 → Phase_out ≥ -PI with no wrap to positive.
4. I=-10000, Q=-10000 → Phase_out = -632486142 ±2048, Mag_out = 23289 ±8; I=0, Q=0 → Phase_out = 0, Mag_out = 0.
5. Strobe held high continuously → Out_VALID every N_ITER+1 cycles, each result matching its sample. Strobes on cycles 3..N_ITER are ignored (Busy=1).
6. Assert s_RST at iteration 7, then release and strobe I=1000, Q=1000 → no stale Out_VALID; result Phase_out = 210828714 ±2048, and all outputs are 0 during reset.
